// File: rtl/ser_tx_framer.sv
// Parallel-to-serial frame transmitter: START pulse, DATA_W bits, idle gap.
// Bits are held CLKS_PER_BIT clocks each; ready_o is the only unregistered output.
module ser_tx_framer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 2,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              start_o,
    output logic              serial_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BW = $clog2(DATA_W);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     clk_q, clk_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              start_d, serial_d, busy_d, done_d;

    // Next bit to send always sits at the head of the shift register
    logic              head;
    logic [DATA_W-1:0] shifted;

    assign head    = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign shifted = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0}
                               : {1'b0, shreg_q[DATA_W-1:1]};

    assign ready_o = (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        clk_d    = clk_q;
        gap_d    = gap_q;
        start_d  = 1'b0;
        serial_d = serial_o;
        busy_d   = busy_o;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b0;
                busy_d   = 1'b0;
                if (valid_i) begin
                    state_d = S_START;
                    shreg_d = data_i;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                state_d  = S_SHIFT;
                serial_d = head;
                shreg_d  = shifted;
                bit_d    = '0;
                clk_d    = '0;
                busy_d   = 1'b1;
            end
            S_SHIFT: begin
                if (clk_q == CLK_LAST) begin
                    clk_d = '0;
                    if (bit_q == BIT_LAST) begin
                        done_d   = 1'b1;
                        serial_d = 1'b0;
                        bit_d    = '0;
                        gap_d    = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = S_GAP;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        serial_d = head;
                        shreg_d  = shifted;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_GAP: begin
                serial_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            clk_q    <= '0;
            gap_q    <= '0;
            start_o  <= 1'b0;
            serial_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            clk_q    <= clk_d;
            gap_q    <= gap_d;
            start_o  <= start_d;
            serial_o <= serial_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end

endmodule

// File: tb/tb_ser_tx_framer.sv
// Bench for ser_tx_framer: three configurations checked every cycle
// against a frame-position model, plus directed frame and corner sequences.
module tb_ser_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic [2:0] vld = 3'b000;
    logic [2:0] ready_w, start_w, serial_w, busy_w, done_w;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ser_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(1), .GAP_CYCLES(2), .MSB_FIRST(1'b1)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld[0]),
        .ready_o(ready_w[0]), .start_o(start_w[0]),
        .serial_o(serial_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
    );

    ser_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(4), .GAP_CYCLES(2), .MSB_FIRST(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld[1]),
        .ready_o(ready_w[1]), .start_o(start_w[1]),
        .serial_o(serial_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
    );

    ser_tx_framer #(
        .DATA_W(8), .CLKS_PER_BIT(3), .GAP_CYCLES(0), .MSB_FIRST(1'b0)
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld[2]),
        .ready_o(ready_w[2]), .start_o(start_w[2]),
        .serial_o(serial_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2])
    );

    function automatic int cpb(int d);
        case (d)
            0: return 1;
            1: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int gap(int d);
        return (d == 2) ? 0 : 2;
    endfunction

    function automatic bit msb(int d);
        return d != 2;
    endfunction

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: t = clocks since the START cycle (1000 = idle).
    // Cycle t=0 is START, bits fill t=1..8*cpb, done at t=1+8*cpb,
    // gap runs until t=1+8*cpb+gap, where the block is idle again.
    int         t [3];
    logic [7:0] mdat [3];

    function automatic logic [4:0] expect_of(int d);
        int   len;
        int   tt;
        int   idx;
        logic s;
        logic [7:0] w;
        len = 1 + 8 * cpb(d);
        tt  = t[d];
        w   = mdat[d];
        s   = 1'b0;
        if (tt >= 1 && tt < len) begin
            idx = (tt - 1) / cpb(d);
            s   = msb(d) ? w[7-idx] : w[idx];
        end
        return {tt >= len + gap(d), tt == 0, s,
                tt < len + gap(d), tt == len};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) t[d] <= 1000;
        end else begin
            for (int d = 0; d < 3; d++) begin
                logic [4:0] e;
                e = expect_of(d);
                if (e[4] && vld[d]) begin
                    t[d]    <= 0;
                    mdat[d] <= data;
                end else if (t[d] < 1000) begin
                    t[d] <= t[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("model dut%0d", d),
                    {ready_w[d], start_w[d], serial_w[d],
                     busy_w[d], done_w[d]},
                    expect_of(d));
            end
        end
    end

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [7:0] bits;
        int         pulse;
    } vec_t;

    vec_t vt [7];

    // Send one word, collect its bit stream and event timing.
    task automatic send(vec_t v);
        int         d;
        int         c;
        int         cst;
        int         cdn;
        int         crd;
        int         nst;
        logic [7:0] got;
        d = v.d;
        c = 0;
        while (!ready_w[d] && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("ready wait dut%0d", d), ready_w[d], 1);
        data   = v.data;
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        cst = -1; cdn = -1; crd = -1; nst = 0; got = '0;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            if (start_w[d]) begin
                nst++;
                if (cst < 0) cst = k;
            end
            if (k >= 2 && (k - 2) % cpb(d) == 0 && (k - 2) / cpb(d) < 8)
                got[7 - (k - 2) / cpb(d)] = serial_w[d];
            if (done_w[d] && cdn < 0) cdn = k;
            if (v.pulse > 0 && k == v.pulse) begin
                data   = 8'h55;
                vld[d] = 1'b1;
            end
            if (v.pulse > 0 && k == v.pulse + 1) vld[d] = 1'b0;
            if (k >= 2 && ready_w[d]) begin
                crd = k;
                break;
            end
        end
        chk($sformatf("start lat %0h", v.data), cst, 1);
        chk($sformatf("start count %0h", v.data), nst, 1);
        chk($sformatf("bits %0h", v.data), got, v.bits);
        chk($sformatf("done lat %0h", v.data), cdn, 2 + 8 * cpb(d));
        chk($sformatf("ready lat %0h", v.data), crd,
            2 + 8 * cpb(d) + gap(d));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            t[d]    = 1000;
            mdat[d] = '0;
        end
        vt[0] = '{0, 8'hB0, 8'b10110000, 0};
        vt[1] = '{1, 8'hA5, 8'b10100101, 0};
        vt[2] = '{2, 8'h0D, 8'b10110000, 0};
        vt[3] = '{0, 8'h0F, 8'b00001111, 4};
        vt[4] = '{0, 8'h3C, 8'b00111100, 0};
        vt[5] = '{2, 8'h80, 8'b00000001, 0};
        vt[6] = '{1, 8'h01, 8'b00000001, 0};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outs", {ready_w, start_w, serial_w, busy_w, done_w},
            {3'b111, 12'h000});
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) send(vt[i]);

        // Back-to-back on the gapless LSB-first instance
        begin
            int cd;
            int cs;
            cd = -1; cs = -1;
            data   = 8'h01;
            vld[2] = 1'b1;
            @(negedge clk);
            data = 8'hFF;
            for (int k = 1; k <= 200; k++) begin
                if (k > 1) @(negedge clk);
                if (done_w[2] && cd < 0) cd = k;
                if (start_w[2] && k > 1) begin
                    cs     = k;
                    vld[2] = 1'b0;
                    break;
                end
            end
            vld[2] = 1'b0;
            chk("b2b done", cd, 26);
            chk("b2b restart gap", cs - cd, 1);
            for (int k = 0; k < 200 && !ready_w[2]; k++) @(negedge clk);
            chk("b2b drain", ready_w[2], 1);
        end

        // Reset in the middle of bit 3 of 8'hC3
        data   = 8'hC3;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", busy_w[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset", {ready_w[0], start_w[0], serial_w[0],
                            busy_w[0], done_w[0]}, 5'b10000);
        #1 rst = 1'b0;
        data   = 8'h81;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        chk("post-reset start", start_w[0], 1);
        repeat (20) @(negedge clk);

        // Random traffic on all three instances
        repeat (900) begin
            @(negedge clk);
            data = 8'($urandom);
            for (int d = 0; d < 3; d++)
                vld[d] = ($urandom_range(0, 3) == 0);
        end
        vld = 3'b000;
        repeat (120) @(negedge clk);
        chk("final idle", ready_w, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
